// File: rtl/prod_accum_if.sv
// Handshake bundle between the multiplier-side producer and prod_accum.
// master drives products and out_ready; slave is the accumulator.
interface prod_accum_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ACC_W = 20
);
  logic [IN_W-1:0]  prod;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       cnt;
  logic             ovf;

  modport master (
    output prod, in_valid, out_ready,
    input  in_ready, acc_out, out_valid, cnt, ovf
  );

  modport slave (
    input  prod, in_valid, out_ready,
    output in_ready, acc_out, out_valid, cnt, ovf
  );
endinterface

// File: rtl/prod_accum.sv
// Batch multiply-accumulate stage: sums LEN unsigned products, then holds the total.
// Define PROD_ACCUM_SAT_EN to saturate on overflow instead of wrapping.
module prod_accum #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ACC_W = 20,
  parameter int unsigned LEN   = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  prod_accum_if.slave   bus
);

`ifdef PROD_ACCUM_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  localparam logic [7:0] LenCnt = 8'(LEN);

  typedef enum logic {StAcc, StDone} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [7:0]       cnt_q;
  logic             ovf_q;

  logic [ACC_W:0]   sum_full;
  logic [ACC_W-1:0] acc_d;
  logic [7:0]       cnt_d;
  logic             carry;

  always_comb begin
    sum_full = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.prod};
    carry    = sum_full[ACC_W];
    cnt_d    = cnt_q + 8'd1;
    // Once saturated, any further nonzero product carries again, so all-ones sticks.
    if (carry && SatEn) begin
      acc_d = '1;
    end else begin
      acc_d = sum_full[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StAcc;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (clr_i) begin
      state_q <= StAcc;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (bus.in_valid) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_q | carry;
            if (cnt_d == LenCnt) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q <= StAcc;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

  // Handshake flags decode from state only; no input-to-output path.
  assign bus.in_ready  = (state_q == StAcc);
  assign bus.out_valid = (state_q == StDone);
  assign bus.acc_out   = acc_q;
  assign bus.cnt       = cnt_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Randomised and directed bench for prod_accum against a true-sum reference model.
// Runs three instances: default, ACC_W=17 for overflow, and LEN=1.
module tb_prod_accum;

`ifdef PROD_ACCUM_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  localparam int NumDut = 3;
  localparam int Width[NumDut] = '{20, 17, 20};
  localparam int Len[NumDut]   = '{4, 4, 1};

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  logic [15:0] prod_v[NumDut];
  logic        iv_v[NumDut];
  logic        or_v[NumDut];
  logic [19:0] acc_o[NumDut];
  logic [7:0]  cnt_o[NumDut];
  logic        ovf_o[NumDut];
  logic        ir_o[NumDut];
  logic        ov_o[NumDut];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: exact (unbounded) running sum per instance.
  longint m_sum[NumDut];
  int     m_cnt[NumDut];
  bit     m_done[NumDut];

  always #5 clk = ~clk;

  prod_accum_if #(.IN_W(16), .ACC_W(20)) if0 ();
  prod_accum_if #(.IN_W(16), .ACC_W(17)) if1 ();
  prod_accum_if #(.IN_W(16), .ACC_W(20)) if2 ();

  prod_accum #(.IN_W(16), .ACC_W(20), .LEN(4)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .bus(if0.slave));
  prod_accum #(.IN_W(16), .ACC_W(17), .LEN(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .bus(if1.slave));
  prod_accum #(.IN_W(16), .ACC_W(20), .LEN(1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .bus(if2.slave));

  assign if0.prod = prod_v[0];  assign if0.in_valid = iv_v[0];  assign if0.out_ready = or_v[0];
  assign if1.prod = prod_v[1];  assign if1.in_valid = iv_v[1];  assign if1.out_ready = or_v[1];
  assign if2.prod = prod_v[2];  assign if2.in_valid = iv_v[2];  assign if2.out_ready = or_v[2];

  assign acc_o[0] = if0.acc_out;       assign cnt_o[0] = if0.cnt;  assign ovf_o[0] = if0.ovf;
  assign acc_o[1] = 20'(if1.acc_out);  assign cnt_o[1] = if1.cnt;  assign ovf_o[1] = if1.ovf;
  assign acc_o[2] = if2.acc_out;       assign cnt_o[2] = if2.cnt;  assign ovf_o[2] = if2.ovf;
  assign ir_o[0] = if0.in_ready;  assign ov_o[0] = if0.out_valid;
  assign ir_o[1] = if1.in_ready;  assign ov_o[1] = if1.out_valid;
  assign ir_o[2] = if2.in_ready;  assign ov_o[2] = if2.out_valid;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint exp_acc(input int i);
    longint max_v = (longint'(1) << Width[i]) - 1;
    if (m_sum[i] > max_v) return Sat ? max_v : (m_sum[i] % (max_v + 1));
    return m_sum[i];
  endfunction

  function automatic bit exp_ovf(input int i);
    return m_sum[i] > ((longint'(1) << Width[i]) - 1);
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NumDut; i++) begin
      if (!rst_n || clr) begin
        m_sum[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
      end else if (m_done[i]) begin
        if (or_v[i]) begin
          m_sum[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
        end
      end else if (iv_v[i]) begin
        m_sum[i] += longint'(prod_v[i]);
        m_cnt[i]++;
        if (m_cnt[i] == Len[i]) m_done[i] = 1;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NumDut; i++) begin
      check_eq($sformatf("acc%0d", i), longint'(acc_o[i]), exp_acc(i));
      check_eq($sformatf("cnt%0d", i), longint'(cnt_o[i]), longint'(m_cnt[i]));
      check_eq($sformatf("ovf%0d", i), longint'(ovf_o[i]), longint'(exp_ovf(i)));
      check_eq($sformatf("in_ready%0d", i), longint'(ir_o[i]), longint'(!m_done[i]));
      check_eq($sformatf("out_valid%0d", i), longint'(ov_o[i]), longint'(m_done[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_all();
    for (int i = 0; i < NumDut; i++) begin
      iv_v[i] = 1'b0; or_v[i] = 1'b1; prod_v[i] = '0;
    end
  endtask

  task automatic send(input int i, input logic [15:0] p);
    iv_v[i] = 1'b1; prod_v[i] = p;
    step();
  endtask

  initial begin
    for (int i = 0; i < NumDut; i++) begin
      m_sum[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
    end
    clr = 1'b0;
    rst_n = 1'b0;
    idle_all();
    for (int i = 0; i < NumDut; i++) begin
      iv_v[i] = 1'b1; prod_v[i] = 16'hFFFF;
    end
    step();
    step();
    check_eq("rst_acc", longint'(acc_o[0]), 0);
    check_eq("rst_in_ready", longint'(ir_o[0]), 1);
    rst_n = 1'b1;
    idle_all();

    // Basic batch with a bubble between the 2nd and 3rd product.
    send(0, 16'd15);
    send(0, 16'd100);
    iv_v[0] = 1'b0;
    step();
    send(0, 16'd65025);
    send(0, 16'd1);
    check_eq("basic_valid", longint'(ov_o[0]), 1);
    check_eq("basic_total", longint'(acc_o[0]), 65141);
    check_eq("basic_cnt", longint'(cnt_o[0]), 4);
    iv_v[0] = 1'b0;
    step();
    check_eq("basic_after_acc", longint'(acc_o[0]), 0);
    check_eq("basic_after_rdy", longint'(ir_o[0]), 1);

    // Backpressure: product stream stays valid while the total is held.
    or_v[0] = 1'b0;
    for (int k = 0; k < 4; k++) send(0, 16'd7);
    for (int k = 0; k < 5; k++) begin
      send(0, 16'd7);
      check_eq("bp_hold_acc", longint'(acc_o[0]), 28);
      check_eq("bp_hold_rdy", longint'(ir_o[0]), 0);
    end
    or_v[0] = 1'b1;
    send(0, 16'd7);
    check_eq("bp_release_cnt", longint'(cnt_o[0]), 0);
    send(0, 16'd7);
    check_eq("bp_first_accept", longint'(cnt_o[0]), 1);
    idle_all();

    // Overflow on the 17-bit instance.
    for (int k = 0; k < 4; k++) send(1, 16'd65025);
    check_eq("ovf_total", longint'(acc_o[1]), Sat ? 131071 : 129028);
    check_eq("ovf_flag", longint'(ovf_o[1]), 1);
    iv_v[1] = 1'b0;
    step();
    check_eq("ovf_cleared", longint'(ovf_o[1]), 0);

    // Clear mid-batch discards both the partial sum and the simultaneous product.
    clr = 1'b1;
    step();
    clr = 1'b0;
    send(0, 16'd500);
    send(0, 16'd600);
    clr = 1'b1;
    send(0, 16'd9);
    clr = 1'b0;
    check_eq("clr_acc", longint'(acc_o[0]), 0);
    check_eq("clr_cnt", longint'(cnt_o[0]), 0);
    for (int k = 1; k <= 4; k++) send(0, 16'(k));
    check_eq("clr_refill", longint'(acc_o[0]), 10);
    idle_all();
    step();

    // LEN=1, continuous stream.
    for (int k = 0; k < 6; k++) begin
      send(2, 16'd42);
      check_eq("len1_valid", longint'(ov_o[2]), (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 0) check_eq("len1_acc", longint'(acc_o[2]), 42);
    end
    idle_all();

    // Random traffic on all instances.
    for (int c = 0; c < 2000; c++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      clr   = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NumDut; i++) begin
        iv_v[i]   = ($urandom_range(0, 3) != 0);
        or_v[i]   = ($urandom_range(0, 2) != 0);
        prod_v[i] = 16'($urandom_range(0, 255) * $urandom_range(0, 255));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
